// File: rtl/usb_ahb_pkg.sv
// Shared AHB-Lite register map and drain FSM state encoding for the USB RX buffer.
// Used by both the drain master and the slave side of the RX data buffer.
package usb_ahb_pkg;

  localparam logic [3:0] ADDR_DATA = 4'h0;
  localparam logic [3:0] ADDR_STAT = 4'h4;
  localparam logic [3:0] ADDR_OCC  = 4'h8;
  localparam logic [3:0] ADDR_CLR  = 4'hD;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int GAP_CNT_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    GAP,
    STAT_A,
    STAT_D,
    OCC_A,
    OCC_D,
    RD_A,
    RD_D,
    PUSH,
    CLR_A,
    CLR_D
  } drain_state_t;

  // Byte counter that sticks at its maximum instead of wrapping.
  function automatic logic [6:0] sat_inc7(input logic [6:0] value);
    return (value == 7'h7F) ? value : value + 7'd1;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Rollover counter: counts 1..rollover_val while enabled; rollover_flag marks the
// cycle whose increment lands on rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (count_enable) begin
      count_next = (count_reg == rollover_val) ? NUM_CNT_BITS'(1) : count_reg + NUM_CNT_BITS'(1);
    end
  end

  assign rollover_flag = count_enable && !clear && (count_next == rollover_val);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/usb_rx_drain_master.sv
// AHB-Lite master that polls the USB RX buffer status, drains every buffered byte
// onto a valid/ready stream, then clears the buffer.
module usb_rx_drain_master
  import usb_ahb_pkg::*;
#(
  parameter int         POLL_GAP  = 16,
  parameter logic [3:0] STAT_ADDR = ADDR_STAT,
  parameter logic [3:0] OCC_ADDR  = ADDR_OCC,
  parameter logic [3:0] DATA_ADDR = ADDR_DATA,
  parameter logic [3:0] CLR_ADDR  = ADDR_CLR
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable,
  output logic        hsel,
  output logic        hwrite,
  output logic [3:0]  haddr,
  output logic [1:0]  htrans,
  output logic [1:0]  hsize,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        err,
  output logic [6:0]  pkt_bytes
);

  drain_state_t state_reg, state_next;
  logic [6:0]   remaining_reg, remaining_next;
  logic [6:0]   pkt_bytes_reg, pkt_bytes_next;
  logic [7:0]   out_data_reg, out_data_next;
  logic         err_reg, err_next;
  logic         gap_done;
  logic         unused_hrdata;

  assign unused_hrdata = ^hrdata[31:8];

  flex_counter #(.NUM_CNT_BITS(GAP_CNT_W)) u_gap_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state_reg != GAP),
    .count_enable (state_reg == GAP),
    .rollover_val (GAP_CNT_W'(POLL_GAP)),
    .rollover_flag(gap_done)
  );

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    pkt_bytes_next = pkt_bytes_reg;
    out_data_next  = out_data_reg;
    err_next       = err_reg;
    hsel           = 1'b0;
    hwrite         = 1'b0;
    haddr          = 4'h0;
    htrans         = HTRANS_IDLE;
    hwdata         = 32'h0;
    out_valid      = 1'b0;
    busy           = !(state_reg inside {IDLE, GAP});

    case (state_reg)
      IDLE: if (enable) state_next = STAT_A;
      GAP:  if (gap_done) state_next = enable ? STAT_A : IDLE;
      STAT_A: begin
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = STAT_ADDR;
        state_next = STAT_D;
      end
      // A slave error in any data phase aborts the drain without a clear.
      STAT_D: begin
        if (hresp) begin
          err_next = 1'b1; state_next = GAP;
        end else if (hready) begin
          state_next = hrdata[0] ? OCC_A : GAP;
        end
      end
      OCC_A: begin
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = OCC_ADDR;
        state_next = OCC_D;
      end
      OCC_D: begin
        if (hresp) begin
          err_next = 1'b1; state_next = GAP;
        end else if (hready) begin
          remaining_next = hrdata[6:0];
          pkt_bytes_next = 7'd0;
          state_next     = (hrdata[6:0] == 7'd0) ? CLR_A : RD_A;
        end
      end
      RD_A: begin
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = DATA_ADDR;
        state_next = RD_D;
      end
      RD_D: begin
        if (hresp) begin
          err_next = 1'b1; state_next = GAP;
        end else if (hready) begin
          out_data_next = hrdata[7:0];
          state_next    = PUSH;
        end
      end
      PUSH: begin
        out_valid = 1'b1;
        if (out_ready) begin
          remaining_next = (remaining_reg == 7'd0) ? 7'd0 : remaining_reg - 7'd1;
          pkt_bytes_next = sat_inc7(pkt_bytes_reg);
          state_next     = (remaining_reg <= 7'd1) ? CLR_A : RD_A;
        end
      end
      CLR_A: begin
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = CLR_ADDR; hwrite = 1'b1;
        state_next = CLR_D;
      end
      CLR_D: begin
        hwdata = 32'h1;
        if (hresp) begin
          err_next = 1'b1; state_next = GAP;
        end else if (hready) begin
          state_next = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      remaining_reg <= 7'd0;
      pkt_bytes_reg <= 7'd0;
      out_data_reg  <= 8'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      pkt_bytes_reg <= pkt_bytes_next;
      out_data_reg  <= out_data_next;
      err_reg       <= err_next;
    end
  end

  assign hsize     = 2'b00;
  assign out_data  = out_data_reg;
  assign err       = err_reg;
  assign pkt_bytes = pkt_bytes_reg;

endmodule

// File: tb/tb_usb_rx_drain_master.sv
// Randomized bench: AHB slave model plus stream scoreboard for usb_rx_drain_master.
module tb_usb_rx_drain_master;

  localparam int PG = 5;
  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        n_rst;
  logic        enable;
  logic        hsel, hwrite;
  logic [3:0]  haddr;
  logic [1:0]  htrans, hsize;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic        busy, err;
  logic [6:0]  pkt_bytes;

  usb_rx_drain_master #(.POLL_GAP(PG)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable),
    .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err), .pkt_bytes(pkt_bytes)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Slave model state and scoreboard queues
  byte_q_t     data_q;
  byte_q_t     exp_bytes;
  int          exp_wr[$];
  int          stat_times[$];
  logic        stat_val = 1'b0;
  int          waits = 0;
  int          err_idx = 0;
  int          rd_idx = 0;
  int          stat_cnt = 0;
  int          rd_addr_cnt = 0;
  int          cyc = 0;
  bit          pend = 0;
  bit          pend_write;
  logic [3:0]  pend_addr;
  int          wait_left;
  bit          stall_req = 0;
  bit          rdy_rand = 0;
  int          stall_left = 0;
  logic [7:0]  held;
  bit          model_err = 0;

  // AHB slave: responds in the data phase that follows each captured address phase.
  always @(negedge clk) begin
    logic [31:0] r;
    cyc++;
    if (pend) begin
      if (wait_left > 0) begin
        hready = 1'b0; hresp = 1'b0; wait_left--;
      end else begin
        r = $urandom;
        hready = 1'b1; hresp = 1'b0; hrdata = r;
        if (pend_write) begin
          chk("write_expected", 32'(exp_wr.size() > 0), 1);
          if (exp_wr.size() > 0) void'(exp_wr.pop_front());
          chk("clr_addr", pend_addr, 4'hD);
          chk("clr_hwdata", hwdata, 32'h1);
          $display("bus write addr=%h data=%h", pend_addr, hwdata);
          data_q.delete();
          stat_val = 1'b0;
        end else begin
          chk("rd_hwdata_zero", hwdata, 32'h0);
          case (pend_addr)
            4'h4: hrdata = {r[31:1], stat_val};
            4'h8: hrdata = {r[31:7], 7'(data_q.size())};
            4'h0: begin
              rd_idx++;
              if (rd_idx == err_idx) hresp = 1'b1;
              else hrdata = {r[31:8], (data_q.size() > 0) ? data_q.pop_front() : 8'h00};
            end
            default: ;
          endcase
          $display("bus read addr=%h data=%h resp=%b", pend_addr, hrdata, hresp);
        end
        pend = 0;
      end
    end
    if (hsel && htrans == 2'b10) begin
      chk("hsize_zero", hsize, 2'b00);
      chk("busy_on_bus", busy, 1'b1);
      pend = 1; pend_write = hwrite; pend_addr = haddr; wait_left = waits;
      if (haddr == 4'h4 && !hwrite) begin stat_cnt++; stat_times.push_back(cyc); end
      if (haddr == 4'h0 && !hwrite) rd_addr_cnt++;
    end
  end

  // Consumer and stream monitor.
  always @(negedge clk) begin
    if (stall_req && out_valid) begin
      stall_req = 0; stall_left = 9; held = out_data; out_ready = 1'b0;
    end else if (stall_left > 0) begin
      out_ready = 1'b0;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, held);
      chk("stall_no_bus", hsel, 1'b0);
      stall_left--;
    end else begin
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (out_valid) chk("push_busy", busy, 1'b1);
    if (out_valid && out_ready) begin
      chk("push_expected", 32'(exp_bytes.size() > 0), 1);
      if (exp_bytes.size() > 0) chk("push_byte", out_data, exp_bytes.pop_front());
      $display("push byte=%h", out_data);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hsel"}, hsel, 1'b0);
    chk({tag, "_htrans"}, htrans, 2'b00);
    chk({tag, "_hwrite"}, hwrite, 1'b0);
    chk({tag, "_haddr"}, haddr, 4'h0);
    chk({tag, "_hsize"}, hsize, 2'b00);
    chk({tag, "_hwdata"}, hwdata, 32'h0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_pkt_bytes"}, pkt_bytes, 7'd0);
  endtask

  // Reference: all bytes before the faulting read are delivered; a clear follows only a clean drain.
  task automatic run_drain(input string name, input byte_q_t bytes, input int w, input int eidx,
                           input bit stall, input bit rrdy);
    int s0, c, n_exp;
    n_exp = (eidx != 0) ? eidx - 1 : bytes.size();
    data_q = bytes;
    for (int i = 0; i < n_exp; i++) exp_bytes.push_back(bytes[i]);
    if (eidx == 0) exp_wr.push_back(1);
    else model_err = 1;
    $display("drain %s: bytes=%0d waits=%0d err_at=%0d", name, bytes.size(), w, eidx);
    stat_val = 1'b1; waits = w; err_idx = eidx; rd_idx = 0; stall_req = stall; rdy_rand = rrdy;
    s0 = stat_cnt;
    enable = 1'b1;
    for (c = 0; c < 100 && stat_cnt == s0; c++) step();
    chk({name, "_poll_started"}, 32'(stat_cnt > s0), 1);
    enable = 1'b0;
    for (c = 0; c < 20000 && busy; c++) step();
    chk({name, "_drain_done"}, busy, 1'b0);
    repeat (PG + 4) step();
    chk({name, "_pushes_left"}, exp_bytes.size(), 0);
    chk({name, "_clears_left"}, exp_wr.size(), 0);
    chk({name, "_pkt_bytes"}, pkt_bytes, n_exp);
    chk({name, "_err"}, err, model_err);
    chk({name, "_idle_hsel"}, hsel, 1'b0);
    data_q.delete(); exp_bytes.delete(); exp_wr.delete();
    stat_val = 1'b0; stall_req = 0; rdy_rand = 0; err_idx = 0;
  endtask

  initial begin
    byte_q_t b;
    int s0, a0, c;
    n_rst = 1'b0; enable = 1'b0; out_ready = 1'b0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    repeat (2) step();
    check_reset_outputs("por");
    n_rst = 1'b1;
    step();

    b = '{8'hA5, 8'h3C, 8'hFF};
    run_drain("basic", b, 0, 0, 0, 0);

    // Empty buffer: only status polls, evenly spaced.
    stat_times.delete();
    stat_val = 1'b0; waits = 0; enable = 1'b1;
    s0 = stat_cnt;
    for (c = 0; c < 300 && stat_cnt < s0 + 4; c++) step();
    chk("poll_count", 32'(stat_cnt >= s0 + 4), 1);
    for (int i = 1; i < 4 && i < stat_times.size(); i++)
      chk("poll_spacing", stat_times[i] - stat_times[i-1], PG + 2);
    enable = 1'b0;
    repeat (PG + 6) step();
    chk("poll_idle_busy", busy, 1'b0);

    b = '{};
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    run_drain("backpressure", b, 0, 0, 1, 0);

    b = '{8'hA5, 8'h3C, 8'hFF};
    run_drain("wait_states", b, 3, 0, 0, 0);

    b = '{};
    run_drain("occ_zero", b, 0, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      b = '{};
      for (int i = 0; i < $urandom_range(1, 12); i++) b.push_back(8'($urandom));
      run_drain("random", b, $urandom_range(0, 3), 0, 0, 1);
    end

    b = '{};
    for (int i = 0; i < 127; i++) b.push_back(8'($urandom));
    run_drain("occ_max", b, 0, 0, 0, 0);

    b = '{};
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom_range(1, 255)));
    run_drain("error", b, 0, 2, 0, 0);

    // Reset while a data read is stalled in its data phase.
    data_q = '{8'h11, 8'h22, 8'h33};
    stat_val = 1'b1; waits = 3; rd_idx = 0;
    a0 = rd_addr_cnt;
    enable = 1'b1;
    for (c = 0; c < 200 && rd_addr_cnt == a0; c++) step();
    chk("rst_reached_rd", 32'(rd_addr_cnt > a0), 1);
    n_rst = 1'b0; enable = 1'b0; pend = 0;
    data_q.delete(); exp_bytes.delete(); exp_wr.delete(); stat_val = 1'b0; model_err = 0;
    step();
    check_reset_outputs("rst_rd_d");
    n_rst = 1'b1;
    s0 = stat_cnt;
    repeat (20) step();
    chk("no_poll_without_enable", stat_cnt - s0, 0);
    enable = 1'b1;
    for (c = 0; c < 10 && stat_cnt == s0; c++) step();
    chk("poll_after_enable", stat_cnt - s0, 1);
    enable = 1'b0;
    repeat (PG + 6) step();
    chk("final_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
